imem_fetch_arbiter: RTL and testbench
=====================================

// Module: imem_fetch_arbiter
// PURPOSE
//  Shares one instruction-memory read port between the two cores' fetch stages.
//  Each core raises a fetch request with a byte address.
//  The arbiter grants one core per cycle, round-robin, and drives the shared memory address.
//  It registers the returned word and hands it back with a one-cycle valid pulse and a stall flag.
//  Sits between the per-core PC/IF logic and a combinational-read instruction memory (word-indexed by addr/4).
// PARAMETERS
//  DEPTH      32  instruction words in the shared memory; valid byte range 0..DEPTH*4-1
//  AW         32  address width (byte address), matches the PC width
//  DW         32  instruction width
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  c0_req_i       in   1   core0 fetch request; held high with addr stable until c0_valid_o
//  c0_addr_i      in   AW  core0 byte address
//  c0_instr_o     out  DW  core0 instruction, meaningful when c0_valid_o=1
//  c0_valid_o     out  1   core0 response pulse, one cycle
//  c0_err_o       out  1   with c0_valid_o: misaligned or out-of-range address
//  c0_stall_o     out  1   comb: c0_req_i & ~c0_valid_o, for the core's hazard unit
//  c1_*           --   --  identical set for core1
//  mem_addr_o     out  AW  address to shared memory (comb from the grant); 0 when idle
//  mem_instr_i    in   DW  combinational read data for mem_addr_o
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; pending[1:0]=0; last_grant=1, so core0 wins the first tie.
//   - Reset is async: asserting it mid-transaction drops pending and any valid in flight.
//   - The requester reissues after reset; no partial response is ever delivered.
//  Eligibility: port p is eligible in cycle N iff req_p=1 & pending_p=0.
//  Grant (comb, cycle N):
//   - only one eligible port: grant it.
//   - both eligible: grant ~last_grant.
//   - none eligible: no grant, mem_addr_o=0.
//  On grant to p in cycle N:
//   - mem_addr_o=addr_p; pending_p<=1; last_grant<=p.
//   - instr register for p <= mem_instr_i, or 0 (NOP) if err.
//   - err = addr_p[1:0]!=0 or addr_p>=DEPTH*4.
//  Cycle N+1:
//   - valid_p=1, instr_p/err_p stable; pending_p<=0.
//   - Port p is ineligible in N+1, even if req_p stays high.
//   - A new address from p is first considered in N+2.
//  Latency: 1 cycle grant-to-valid when uncontended.
//  Worst-case wait: 1 extra cycle behind the other core.
//  Throughput: both requesting continuously gives alternate grants every cycle, so the memory port is 100% busy.
//  instr_p/err_p hold their last value after valid drops; consumers use valid only.
//  req_p dropped while pending: the response is still delivered in N+1 and may be ignored.
//  Address width rule: compare the full AW address against DEPTH*4; no truncation before the range check.
//  last_grant updates only on an actual grant, never in idle cycles.
// STRUCTURE
//  Shared package (cpu_pkg): DW/AW defaults, NOP encoding (32'b0), core-id constants CORE0=0/CORE1=1.
//  One sub-module is natural: rr_arbiter2 (2-way round-robin; inputs elig[1:0] and last_grant; outputs grant[1:0] onehot0).
//  Per-port response registers instantiated twice via generate.
// TESTING
//  1. Reset, then c0 req addr 0x8 -> mem_addr_o=0x8 same cycle; next cycle c0_valid_o=1, c0_instr_o=mem[2], c0_err_o=0.
//  2. Both req from reset (c0=0x0, c1=0x4) held -> grant sequence c0,c1,c0,c1; c0 and c1 valid pulses alternate every cycle.
//  3. c0 holds req high across valid -> no grant to c0 in the valid cycle; regranted the next cycle; valid at most every 2nd cycle.
//  4. c1 addr 0x6 -> c1_valid_o=1, c1_err_o=1, c1_instr_o=0. c1 addr 0x80 (DEPTH=32) -> err=1, instr=0.
//  5. Assert rst_i async between grant and valid -> valid stays 0, pending=0; after release c0 wins the first tie.
//  6. c0 only, continuous, addr 0,4,8... -> c0_stall_o high in grant cycles; each word returned in order; c1 outputs stay 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants for the dual-core fetch path: default widths,
// the NOP encoding returned on bad fetches, and the core-id values.
package cpu_pkg;
    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;
    localparam logic [31:0] NOP    = 32'b0;
    localparam logic        CORE0  = 1'b0;
    localparam logic        CORE1  = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time
// is granted; grant_o is one-hot or zero.
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic [1:0] elig_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (elig_i[0] && (!elig_i[1] || last_grant_i == CORE1)) begin
            grant_o[0] = 1'b1;
        end else if (elig_i[1]) begin
            grant_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational-read instruction memory between two cores' fetch
// stages; one grant per cycle, registered response with a one-cycle valid pulse.
module imem_fetch_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          c0_req_i,
    input  logic [AW-1:0] c0_addr_i,
    output logic [DW-1:0] c0_instr_o,
    output logic          c0_valid_o,
    output logic          c0_err_o,
    output logic          c0_stall_o,
    input  logic          c1_req_i,
    input  logic [AW-1:0] c1_addr_i,
    output logic [DW-1:0] c1_instr_o,
    output logic          c1_valid_o,
    output logic          c1_err_o,
    output logic          c1_stall_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_instr_i
);

    // Full-width limit so high address bits are never ignored by the range check.
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH * 4);

    logic [1:0]    req_w;
    logic [AW-1:0] addr_w [2];
    logic [1:0]    elig_w;
    logic [1:0]    grant_w;
    logic [1:0]    pending_w;
    logic [DW-1:0] instr_w [2];
    logic [1:0]    err_w;
    logic          last_grant_q;
    logic          last_grant_d;

    assign req_w     = {c1_req_i, c0_req_i};
    assign addr_w[0] = c0_addr_i;
    assign addr_w[1] = c1_addr_i;

    // A port answered this cycle is skipped so it cannot win two cycles in a row.
    assign elig_w = rst_i ? 2'b00 : (req_w & ~pending_w);

    rr_arbiter2 u_arb (
        .elig_i       (elig_w),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_w)
    );

    always_comb begin
        mem_addr_o   = '0;
        last_grant_d = last_grant_q;
        if (grant_w[0]) begin
            mem_addr_o   = c0_addr_i;
            last_grant_d = CORE0;
        end else if (grant_w[1]) begin
            mem_addr_o   = c1_addr_i;
            last_grant_d = CORE1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= CORE1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic          pending_q;
        logic [DW-1:0] instr_q;
        logic          err_q;
        logic          err_d;

        assign err_d = (addr_w[p][1:0] != 2'b00) || (addr_w[p] >= LIMIT);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pending_q <= 1'b0;
                instr_q   <= '0;
                err_q     <= 1'b0;
            end else begin
                pending_q <= grant_w[p];
                if (grant_w[p]) begin
                    err_q   <= err_d;
                    instr_q <= err_d ? DW'(NOP) : mem_instr_i;
                end
            end
        end

        assign pending_w[p] = pending_q;
        assign instr_w[p]   = instr_q;
        assign err_w[p]     = err_q;
    end

    assign c0_valid_o = pending_w[0];
    assign c0_instr_o = instr_w[0];
    assign c0_err_o   = err_w[0];
    assign c0_stall_o = c0_req_i & ~pending_w[0];
    assign c1_valid_o = pending_w[1];
    assign c1_instr_o = instr_w[1];
    assign c1_err_o   = err_w[1];
    assign c1_stall_o = c1_req_i & ~pending_w[1];

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: vector table, hand-written reset sequences,
// and randomized traffic against a request-level reference model.
module tb_imem_fetch_arbiter;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        c0_req_i, c1_req_i;
    logic [31:0] c0_addr_i, c1_addr_i;
    logic [31:0] c0_instr_o, c1_instr_o;
    logic        c0_valid_o, c0_err_o, c0_stall_o;
    logic        c1_valid_o, c1_err_o, c1_stall_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_instr_i;

    logic [31:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    imem_fetch_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .c0_req_i(c0_req_i), .c0_addr_i(c0_addr_i), .c0_instr_o(c0_instr_o),
        .c0_valid_o(c0_valid_o), .c0_err_o(c0_err_o), .c0_stall_o(c0_stall_o),
        .c1_req_i(c1_req_i), .c1_addr_i(c1_addr_i), .c1_instr_o(c1_instr_o),
        .c1_valid_o(c1_valid_o), .c1_err_o(c1_err_o), .c1_stall_o(c1_stall_o),
        .mem_addr_o(mem_addr_o), .mem_instr_i(mem_instr_i)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (mem_addr_o < DEPTH * 4) mem_instr_i = mem[mem_addr_o[6:2]];
        else                        mem_instr_i = 32'hDEAD_BEEF;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owes a response next cycle, and what each core last received.
    int          last_w;
    bit          due [2];
    logic [31:0] ex_i [2];
    bit          ex_e [2];

    task automatic model_reset();
        last_w = 1;
        for (int p = 0; p < 2; p++) begin
            due[p] = 0; ex_i[p] = 0; ex_e[p] = 0;
        end
    endtask

    task automatic model_check_and_advance();
        bit          el0, el1, werr;
        int          w;
        logic [31:0] wa;
        chk("c0_valid", 32'(c0_valid_o), 32'(due[0]));
        chk("c1_valid", 32'(c1_valid_o), 32'(due[1]));
        chk("c0_instr", c0_instr_o, ex_i[0]);
        chk("c1_instr", c1_instr_o, ex_i[1]);
        chk("c0_err", 32'(c0_err_o), 32'(ex_e[0]));
        chk("c1_err", 32'(c1_err_o), 32'(ex_e[1]));
        chk("c0_stall", 32'(c0_stall_o), 32'(c0_req_i && !due[0]));
        chk("c1_stall", 32'(c1_stall_o), 32'(c1_req_i && !due[1]));
        el0 = c0_req_i && !due[0];
        el1 = c1_req_i && !due[1];
        if (el0 && el1) w = 1 - last_w;
        else if (el0)   w = 0;
        else if (el1)   w = 1;
        else            w = -1;
        wa = (w == 0) ? c0_addr_i : (w == 1) ? c1_addr_i : 32'h0;
        chk("mem_addr", mem_addr_o, wa);
        due[0] = (w == 0);
        due[1] = (w == 1);
        if (w >= 0) begin
            werr    = (wa % 4 != 0) || (wa >= DEPTH * 4);
            ex_e[w] = werr;
            ex_i[w] = werr ? 32'h0 : mem[wa / 4];
            last_w  = w;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1; c0_req_i = 0; c1_req_i = 0; c0_addr_i = 0; c1_addr_i = 0;
        @(negedge clk);
        rst_i = 0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0, 1:    return 32'($urandom_range(0, DEPTH - 1)) * 4;
            2:       return 32'($urandom_range(0, DEPTH * 4 - 1));
            3:       return 32'(DEPTH * 4 + $urandom_range(0, 64));
            default: return 32'h8000_0000 | (32'($urandom_range(0, DEPTH - 1)) * 4);
        endcase
    endfunction

    typedef struct {
        bit rst; bit r0; logic [31:0] a0; bit r1; logic [31:0] a1;
        logic [31:0] ma;
        bit v0; bit e0; logic [31:0] i0;
        bit v1; bit e1; logic [31:0] i1;
        bit s0; bit s1;
    } vec_t;

    vec_t tbl [21];
    bit   rq [2];
    logic [31:0] ad [2];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst_i = 1; c0_req_i = 0; c1_req_i = 0; c0_addr_i = 0; c1_addr_i = 0;

        //         rst r0 a0    r1 a1      ma       v0 e0 i0            v1 e1 i1            s0 s1
        tbl[0]  = '{1, 0, 0,    0, 0,      0,       0, 0, 0,            0, 0, 0,            0, 0};
        tbl[1]  = '{0, 1, 8,    0, 0,      8,       0, 0, 0,            0, 0, 0,            1, 0};
        tbl[2]  = '{0, 1, 8,    0, 0,      0,       1, 0, 32'hA0000002, 0, 0, 0,            0, 0};
        tbl[3]  = '{0, 0, 0,    0, 0,      0,       0, 0, 32'hA0000002, 0, 0, 0,            0, 0};
        tbl[4]  = '{1, 0, 0,    0, 0,      0,       0, 0, 0,            0, 0, 0,            0, 0};
        tbl[5]  = '{0, 1, 0,    1, 4,      0,       0, 0, 0,            0, 0, 0,            1, 1};
        tbl[6]  = '{0, 1, 0,    1, 4,      4,       1, 0, 32'hA0000000, 0, 0, 0,            0, 1};
        tbl[7]  = '{0, 1, 0,    1, 4,      0,       0, 0, 32'hA0000000, 1, 0, 32'hA0000001, 1, 0};
        tbl[8]  = '{0, 1, 0,    1, 4,      4,       1, 0, 32'hA0000000, 0, 0, 32'hA0000001, 0, 1};
        tbl[9]  = '{0, 0, 0,    0, 0,      0,       0, 0, 32'hA0000000, 1, 0, 32'hA0000001, 0, 0};
        tbl[10] = '{0, 0, 0,    1, 6,      6,       0, 0, 32'hA0000000, 0, 0, 32'hA0000001, 0, 1};
        tbl[11] = '{0, 0, 0,    1, 6,      0,       0, 0, 32'hA0000000, 1, 1, 0,            0, 0};
        tbl[12] = '{0, 0, 0,    1, 'h80,   'h80,    0, 0, 32'hA0000000, 0, 1, 0,            0, 1};
        tbl[13] = '{0, 0, 0,    1, 'h80,   0,       0, 0, 32'hA0000000, 1, 1, 0,            0, 0};
        tbl[14] = '{0, 0, 0,    1, 'h7C,   'h7C,    0, 0, 32'hA0000000, 0, 1, 0,            0, 1};
        tbl[15] = '{0, 0, 0,    0, 0,      0,       0, 0, 32'hA0000000, 1, 0, 32'hA000001F, 0, 0};
        tbl[16] = '{0, 1, 4,    0, 0,      4,       0, 0, 32'hA0000000, 0, 0, 32'hA000001F, 1, 0};
        tbl[17] = '{0, 1, 4,    0, 0,      0,       1, 0, 32'hA0000001, 0, 0, 32'hA000001F, 0, 0};
        tbl[18] = '{0, 1, 4,    0, 0,      4,       0, 0, 32'hA0000001, 0, 0, 32'hA000001F, 1, 0};
        tbl[19] = '{0, 1, 4,    0, 0,      0,       1, 0, 32'hA0000001, 0, 0, 32'hA000001F, 0, 0};
        tbl[20] = '{0, 0, 0,    0, 0,      0,       0, 0, 32'hA0000001, 0, 0, 32'hA000001F, 0, 0};

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst_i = tbl[i].rst;
            c0_req_i = tbl[i].r0; c0_addr_i = tbl[i].a0;
            c1_req_i = tbl[i].r1; c1_addr_i = tbl[i].a1;
            #1;
            chk($sformatf("v%0d mem_addr", i), mem_addr_o, tbl[i].ma);
            chk($sformatf("v%0d c0_valid", i), 32'(c0_valid_o), 32'(tbl[i].v0));
            chk($sformatf("v%0d c0_err", i),   32'(c0_err_o),   32'(tbl[i].e0));
            chk($sformatf("v%0d c0_instr", i), c0_instr_o,      tbl[i].i0);
            chk($sformatf("v%0d c1_valid", i), 32'(c1_valid_o), 32'(tbl[i].v1));
            chk($sformatf("v%0d c1_err", i),   32'(c1_err_o),   32'(tbl[i].e1));
            chk($sformatf("v%0d c1_instr", i), c1_instr_o,      tbl[i].i1);
            chk($sformatf("v%0d c0_stall", i), 32'(c0_stall_o), 32'(tbl[i].s0));
            chk($sformatf("v%0d c1_stall", i), 32'(c1_stall_o), 32'(tbl[i].s1));
        end

        // Reset asserted between grant and valid: the response must never appear.
        do_reset();
        @(negedge clk);
        c0_req_i = 1; c0_addr_i = 32'h10;
        #1 chk("rst_mid mem_addr", mem_addr_o, 32'h10);
        #2 rst_i = 1;
        @(posedge clk);
        #1;
        chk("rst_mid c0_valid", 32'(c0_valid_o), 0);
        chk("rst_mid c0_instr", c0_instr_o, 0);
        @(negedge clk);
        rst_i = 0; c0_req_i = 1; c0_addr_i = 32'h10; c1_req_i = 1; c1_addr_i = 32'h4;
        #1 chk("rst_tie mem_addr", mem_addr_o, 32'h10);
        @(posedge clk);
        #1;
        chk("rst_tie c0_valid", 32'(c0_valid_o), 1);
        chk("rst_tie c0_instr", c0_instr_o, 32'hA0000004);
        #1 rst_i = 1;
        #1;
        chk("rst_async c0_valid", 32'(c0_valid_o), 0);
        chk("rst_async c0_instr", c0_instr_o, 0);
        @(negedge clk);
        rst_i = 0; c0_req_i = 0; c1_req_i = 0;

        // Core0 streaming alone through every word in order.
        do_reset();
        begin
            int k = 0;
            while (k < DEPTH) begin
                @(negedge clk);
                c0_req_i = 1;
                c0_addr_i = 32'(k) * 4;
                #1 model_check_and_advance();
                if (c0_valid_o) k++;
            end
            @(negedge clk);
            c0_req_i = 0;
            #1 model_check_and_advance();
        end

        // Randomized traffic from both cores.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        do_reset();
        rq[0] = 0; rq[1] = 0; ad[0] = 0; ad[1] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!rq[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rq[p] = 1; ad[p] = rand_addr();
                    end
                end else if (due[p]) begin
                    if ($urandom_range(0, 2) == 0) rq[p] = 0;
                    else ad[p] = rand_addr();
                end else if ($urandom_range(0, 15) == 0) begin
                    rq[p] = 0;
                end
            end
            c0_req_i = rq[0]; c0_addr_i = ad[0];
            c1_req_i = rq[1]; c1_addr_i = ad[1];
            #1 model_check_and_advance();
        end

        @(negedge clk);
        c0_req_i = 0; c1_req_i = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
